// File: rtl/alu_pkg.sv
// Shared ALU encodings: opcodes, PSR bit positions and the flag write mask,
// plus the control word that travels with an instruction through the stage.
package alu_pkg;

    localparam int REG_AW = 4;

    localparam logic [7:0] OP_AND  = 8'h01;
    localparam logic [7:0] OP_OR   = 8'h02;
    localparam logic [7:0] OP_XOR  = 8'h03;
    localparam logic [7:0] OP_NOT  = 8'h04;
    localparam logic [7:0] OP_ADD  = 8'h05;
    localparam logic [7:0] OP_ADDU = 8'h06;
    localparam logic [7:0] OP_ADDC = 8'h07;
    localparam logic [7:0] OP_RSH  = 8'h08;
    localparam logic [7:0] OP_SUB  = 8'h09;
    localparam logic [7:0] OP_CMP  = 8'h0B;
    localparam logic [7:0] OP_ALSH = 8'h0C;
    localparam logic [7:0] OP_ARSH = 8'h0F;
    localparam logic [7:0] OP_LSH  = 8'h84;

    localparam int PSR_C = 0;
    localparam int PSR_L = 2;
    localparam int PSR_F = 5;
    localparam int PSR_Z = 6;
    localparam int PSR_N = 7;

    // Only C, L, F, Z and N are architectural; the other PSR bits read as 0.
    localparam logic [7:0] PSR_MASK = 8'hE5;

    // Control carried alongside the registered operands until retire.
    typedef struct packed {
        logic [7:0]        opcode;
        logic [REG_AW-1:0] rdest;
        logic              wb_en;
    } op_ctrl_t;

    // Opcodes whose ALU flags are written back into the PSR.
    function automatic logic is_flag_op(input logic [7:0] opcode);
        logic hit;
        case (opcode)
            OP_ADD, OP_ADDC, OP_SUB, OP_CMP: hit = 1'b1;
            default:                         hit = 1'b0;
        endcase
        return hit;
    endfunction

endpackage

// File: rtl/regfile_2r1w.sv
// General register file: two combinational operand read ports, one write
// port and a debug read port. Reads see the stored value only (no bypass).
module regfile_2r1w #(
    parameter int NUM_REGS = 16,
    parameter int DATA_W   = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we_i,
    input  logic [3:0]        waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [3:0]        raddr_a_i,
    output logic [DATA_W-1:0] rdata_a_o,
    input  logic [3:0]        raddr_b_i,
    output logic [DATA_W-1:0] rdata_b_o,
    input  logic [3:0]        dbg_raddr_i,
    output logic [DATA_W-1:0] dbg_rdata_o
);

    logic [DATA_W-1:0] mem_q [NUM_REGS];

    // Storage update: clear on reset, single write port otherwise.
    // NOTE: the array is reset deliberately because software expects every
    // register to read 0 after reset; this costs a flop-based array.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                mem_q[i] <= '0;
            end
        end else if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_a_o   = mem_q[raddr_a_i];
    assign rdata_b_o   = mem_q[raddr_b_i];
    assign dbg_rdata_o = mem_q[dbg_raddr_i];

endmodule

// File: rtl/alu_operand_stage.sv
// Operand-fetch / writeback stage around the combinational ALU. Captures one
// instruction per cycle with result bypass, presents it to the ALU for one
// cycle, then writes the result to the register file and flags to the PSR.
module alu_operand_stage
    import alu_pkg::*;
#(
    parameter int NUM_REGS = 16,
    parameter int DATA_W   = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              issue_valid,
    output logic              issue_ready,
    input  logic [7:0]        issue_opcode,
    input  logic [3:0]        issue_rsrc,
    input  logic [3:0]        issue_rdest,
    input  logic [DATA_W-1:0] issue_imm,
    input  logic              issue_imm_en,
    input  logic              issue_wb_en,
    input  logic              stall,
    output logic [DATA_W-1:0] alu_r1,
    output logic [DATA_W-1:0] alu_r2,
    output logic [7:0]        alu_opcode,
    output logic [7:0]        alu_flags_in,
    input  logic [DATA_W-1:0] alu_result,
    input  logic [7:0]        alu_flags_out,
    output logic              op_valid,
    output logic [7:0]        psr,
    input  logic [3:0]        dbg_raddr,
    output logic [DATA_W-1:0] dbg_rdata
);

    logic [DATA_W-1:0] alu_r1_q, alu_r1_d;
    logic [DATA_W-1:0] alu_r2_q, alu_r2_d;
    op_ctrl_t          ctrl_q, ctrl_d;
    logic              op_valid_q, op_valid_d;
    logic [7:0]        psr_q, psr_d;

    logic              accept;
    logic              retire;
    logic              wb_fire;
    logic              flag_pending;
    logic [DATA_W-1:0] rsrc_rdata, rdest_rdata;
    logic [DATA_W-1:0] rsrc_val, rdest_val;

    assign accept       = issue_valid && !stall;
    assign retire       = op_valid_q && !stall;
    assign wb_fire      = retire && ctrl_q.wb_en;
    // The instruction at the ALU produces flags the next op may consume
    // before the PSR register has caught up.
    assign flag_pending = op_valid_q && is_flag_op(ctrl_q.opcode);

    regfile_2r1w #(
        .NUM_REGS (NUM_REGS),
        .DATA_W   (DATA_W)
    ) u_regfile (
        .clk         (clk),
        .rst_n       (rst_n),
        .we_i        (wb_fire),
        .waddr_i     (ctrl_q.rdest),
        .wdata_i     (alu_result),
        .raddr_a_i   (issue_rsrc),
        .rdata_a_o   (rsrc_rdata),
        .raddr_b_i   (issue_rdest),
        .rdata_b_o   (rdest_rdata),
        .dbg_raddr_i (dbg_raddr),
        .dbg_rdata_o (dbg_rdata)
    );

    // Bypass: a read of the register being written this edge takes the ALU result.
    assign rsrc_val  = (wb_fire && (issue_rsrc  == ctrl_q.rdest)) ? alu_result : rsrc_rdata;
    assign rdest_val = (wb_fire && (issue_rdest == ctrl_q.rdest)) ? alu_result : rdest_rdata;

    // Next-state for operands, control, valid and PSR; stall freezes all of it.
    // NOTE: every target gets a hold default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        alu_r1_d   = alu_r1_q;
        alu_r2_d   = alu_r2_q;
        ctrl_d     = ctrl_q;
        op_valid_d = op_valid_q;
        psr_d      = psr_q;
        if (!stall) begin
            op_valid_d = accept;
            if (accept) begin
                alu_r1_d      = issue_imm_en ? issue_imm : rsrc_val;
                alu_r2_d      = rdest_val;
                ctrl_d.opcode = issue_opcode;
                ctrl_d.rdest  = issue_rdest;
                ctrl_d.wb_en  = issue_wb_en;
            end
            if (retire && is_flag_op(ctrl_q.opcode)) begin
                psr_d = alu_flags_out & PSR_MASK;
            end
        end
    end

    // Stage registers; reset discards any in-flight instruction.
    // NOTE: state is updated with non-blocking assignments so every register
    // samples values from before the edge, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_r1_q   <= '0;
            alu_r2_q   <= '0;
            ctrl_q     <= '{opcode: 8'h00, rdest: '0, wb_en: 1'b0};
            op_valid_q <= 1'b0;
            psr_q      <= '0;
        end else begin
            alu_r1_q   <= alu_r1_d;
            alu_r2_q   <= alu_r2_d;
            ctrl_q     <= ctrl_d;
            op_valid_q <= op_valid_d;
            psr_q      <= psr_d;
        end
    end

    assign issue_ready  = !stall;
    assign alu_r1       = alu_r1_q;
    assign alu_r2       = alu_r2_q;
    assign alu_opcode   = ctrl_q.opcode;
    assign op_valid     = op_valid_q;
    assign psr          = psr_q;
    assign alu_flags_in = flag_pending ? (alu_flags_out & PSR_MASK) : psr_q;

endmodule
